spi_cmd_scheduler: RTL

Shares the single SPI master (the LED-control link to `spi_top`) between up to `NUM_REQ` on-chip requesters. It accepts 24-bit command frames (`{cmd, addr, payload}`) over per-requester valid/ready handshakes and grants them round-robin. For each granted frame it drives the master's `tx_enb`/`i_frame`, tracks `cs` to detect transfer start and completion, and returns the master's received frame tagged with the requester ID.

---
 rtl/spi_cmd_scheduler_pkg.sv | 28 ++
 rtl/spi_cmd_scheduler_if.sv | 34 +++
 rtl/spi_cmd_scheduler_rr_arbiter.sv | 42 ++++
 rtl/spi_cmd_scheduler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/spi_cmd_scheduler_pkg.sv
// Shared frame layout, command codes and sizing helpers for the SPI command scheduler.
package spi_cmd_scheduler_pkg;

    localparam int unsigned CMD_BITS           = 8;
    localparam int unsigned ADDR_BITS          = 8;
    localparam int unsigned PAYLOAD_BITS       = 8;
    localparam int unsigned MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;

    localparam int unsigned SCHED_NUM_REQ_DEFAULT = 4;

    localparam logic [CMD_BITS-1:0]  CMD_NOP     = 8'h00;
    localparam logic [CMD_BITS-1:0]  CMD_LED_SET = 8'h01;
    localparam logic [CMD_BITS-1:0]  CMD_LED_CLR = 8'h02;
    localparam logic [CMD_BITS-1:0]  CMD_READ    = 8'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_NONE   = 8'hFF;

    typedef struct packed {
        logic [CMD_BITS-1:0]     cmd;
        logic [ADDR_BITS-1:0]    addr;
        logic [PAYLOAD_BITS-1:0] payload;
    } frame_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_cmd_scheduler_if.sv
// Requester handshakes, SPI master link and response channel of the command scheduler.
interface spi_cmd_scheduler_if
    import spi_cmd_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = SCHED_NUM_REQ_DEFAULT
);
    localparam int unsigned ID_W = id_width(NUM_REQ);

    logic   [NUM_REQ-1:0] req_valid;
    frame_t [NUM_REQ-1:0] req_frame;
    logic   [NUM_REQ-1:0] req_ready;
    logic                 tx_enb;
    frame_t               i_frame;
    logic                 m_cs;
    frame_t               m_o_frame;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    frame_t               rsp_frame;
    logic                 rsp_err;
    logic                 busy;

    // Environment side: requesters plus the SPI master.
    modport master (
        output req_valid, req_frame, m_cs, m_o_frame,
        input  req_ready, tx_enb, i_frame, rsp_valid, rsp_id, rsp_frame, rsp_err, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_frame, m_cs, m_o_frame,
        output req_ready, tx_enb, i_frame, rsp_valid, rsp_id, rsp_frame, rsp_err, busy
    );

endinterface

// File: rtl/spi_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
module rr_arbiter
    import spi_cmd_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_REQ = SCHED_NUM_REQ_DEFAULT,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_valid_o
);
    localparam int unsigned SW = ID_W + 1;

    logic [SW-1:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    assign any_valid_o = |req_valid_i;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_i} + SW'(i);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req_valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant, tx_enb pulse,
// cs-tracked completion and a tagged response per transfer.
module spi_cmd_scheduler
    import spi_cmd_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ       = SCHED_NUM_REQ_DEFAULT,
    parameter int unsigned TX_ENB_CYCLES = 2,
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input logic               sysclk,
    input logic               rst_n,
    spi_cmd_scheduler_if.slave bus
);
    localparam int unsigned ID_W    = id_width(NUM_REQ);
    localparam int unsigned CNT_MAX_A = (TX_ENB_CYCLES > GAP_CYCLES) ? TX_ENB_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (START_TIMEOUT > CNT_MAX_A) ? START_TIMEOUT : CNT_MAX_A;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        RESP      = 3'd4,
        GAP       = 3'd5
    } state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] cur_id_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            tx_enb_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic            busy_q;
    frame_t          i_frame_q;
    frame_t          rsp_frame_q;

    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    grant_idx_c;
    logic               any_valid_c;
    logic               accept_c;
    logic [ID_W-1:0]    ptr_next_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid_i (bus.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant_c),
        .grant_idx_o (grant_idx_c),
        .any_valid_o (any_valid_c)
    );

    // No grant while the master still holds cs low (e.g. after a mid-transfer reset).
    assign accept_c   = rst_n && (state_q == IDLE) && bus.m_cs && any_valid_c;
    assign ptr_next_c = (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);

    assign bus.req_ready = accept_c ? grant_c : '0;
    assign bus.tx_enb    = tx_enb_q;
    assign bus.i_frame   = i_frame_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_frame = rsp_frame_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            rsp_id_q    <= '0;
            tx_enb_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            i_frame_q   <= '0;
            rsp_frame_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        i_frame_q <= bus.req_frame[grant_idx_c];
                        cur_id_q  <= grant_idx_c;
                        rr_ptr_q  <= ptr_next_c;
                        cnt_q     <= '0;
                        tx_enb_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_W'(TX_ENB_CYCLES - 1)) begin
                        tx_enb_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= WAIT_LOW;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // cs may already have fallen during START; it is still low here.
                WAIT_LOW: begin
                    if (!bus.m_cs) begin
                        state_q <= WAIT_HIGH;
                    end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                        rsp_frame_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_id_q    <= cur_id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (bus.m_cs) begin
                        rsp_frame_q <= bus.m_o_frame;
                        rsp_err_q   <= 1'b0;
                        rsp_id_q    <= cur_id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    cnt_q   <= '0;
                    state_q <= GAP;
                end
                GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_enb_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule
